// File: rtl/multicycle_datapath.sv
// Multi-cycle datapath with an integrated control FSM.
// Instruction memory is external and combinational. Data memory is external
// and accessed through a req/ready handshake.
// Optional build macro: MCDP_R0_ZERO_EN makes R0 read as zero and discards
// writes to it. Without the macro, R0 is an ordinary register.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_FETCH  | latch IR from imem_data
// S_DECODE | latch A = R[rs]; B = R[rt], or B = R[rd] for SW/BEQ
// S_EXEC   | ALU result into ALUOut/zero; BEQ/NOP retire here
// S_MEM    | hold the data-memory request until mem_ready
// S_WB     | write rd, then advance the PC
// S_HALT   | frozen until reset
module multicycle_datapath #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 5,
  parameter int DADDR_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic [15:0]        i_imem_data,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [DADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0]  o_mem_wdata,
  input  logic               i_mem_ready,
  input  logic [DATA_W-1:0]  i_mem_rdata,
  input  logic [2:0]         i_dbg_sel,
  output logic [DATA_W-1:0]  o_dbg_data,
  output logic               o_zero,
  output logic               o_halted,
  output logic               o_illegal,
  output logic [15:0]        o_retired
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SLT  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_LW   = 5'b01001;
  localparam logic [4:0] OP_SW   = 5'b01010;
  localparam logic [4:0] OP_BEQ  = 5'b01011;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t              r_state, w_next;
  logic [PC_W-1:0]     r_pc;
  logic [15:0]         r_ir;
  logic [DATA_W-1:0]   r_a, r_b, r_alu, r_mdr;
  logic [DATA_W-1:0]   r_regs [8];
  logic                r_zero, r_illegal, r_mem_req, r_mem_we;
  logic [15:0]         r_retired;

  logic [4:0]          w_op;
  logic [2:0]          w_rd, w_rs, w_rt;
  logic [DATA_W-1:0]   w_imm_d, w_alu;
  logic [PC_W-1:0]     w_imm_pc;
  logic                w_legal, w_is_alu, w_retire, w_wr_en;
  logic [DATA_W-1:0]   w_rf [8];

  assign w_op     = r_ir[15:11];
  assign w_rd     = r_ir[10:8];
  assign w_rs     = r_ir[7:5];
  assign w_rt     = r_ir[4:2];
  assign w_imm_d  = DATA_W'($signed(r_ir[4:0]));
  assign w_imm_pc = PC_W'($signed(r_ir[4:0]));
  assign w_is_alu = (w_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI});
  assign w_legal  = w_is_alu || (w_op inside {OP_LW, OP_SW, OP_BEQ, OP_HALT});

  // Register-file read view; R0 may be forced to zero on every read path.
  always_comb begin
    for (int i = 0; i < 8; i++) w_rf[i] = r_regs[i];
`ifdef MCDP_R0_ZERO_EN
    w_rf[0] = '0;
`endif
  end

`ifdef MCDP_R0_ZERO_EN
  assign w_wr_en = (r_state == S_WB) && (w_rd != 3'd0);
`else
  assign w_wr_en = (r_state == S_WB);
`endif

  // ALU: undefined opcodes fall through to an add whose result is never written.
  always_comb begin
    w_alu = r_a + r_b;
    case (w_op)
      OP_SUB:                 w_alu = r_a - r_b;
      OP_AND:                 w_alu = r_a & r_b;
      OP_OR:                  w_alu = r_a | r_b;
      OP_SLT:                 w_alu = ($signed(r_a) < $signed(r_b)) ? DATA_W'(1) : '0;
      OP_ADDI, OP_LW, OP_SW:  w_alu = r_a + w_imm_d;
      OP_BEQ:                 w_alu = r_a - r_b;
      default:                ;
    endcase
  end

  // Next-state logic for the control FSM.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_is_alu)                          w_next = S_WB;
        else if (w_op == OP_LW || w_op == OP_SW) w_next = S_MEM;
        else if (w_op == OP_HALT)              w_next = S_HALT;
        else                                   w_next = S_FETCH;
      end
      S_MEM:    if (i_mem_ready) w_next = (w_op == OP_SW) ? S_FETCH : S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // An instruction retires on its final edge; HALT never does.
  assign w_retire = (r_state == S_WB)
                 || (r_state == S_MEM && i_mem_ready && w_op == OP_SW)
                 || (r_state == S_EXEC && w_next == S_FETCH);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Datapath registers, handshake outputs and status counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu     <= '0;
      r_mdr     <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_retired <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH:  r_ir <= i_imem_data;
        S_DECODE: begin
          r_a <= w_rf[w_rs];
          r_b <= (w_op == OP_SW || w_op == OP_BEQ) ? w_rf[w_rd] : w_rf[w_rt];
        end
        S_EXEC: begin
          r_alu  <= w_alu;
          r_zero <= (w_alu == '0);
          if (!w_legal) r_illegal <= 1'b1;
          if (w_next == S_MEM) begin
            r_mem_req <= 1'b1;
            r_mem_we  <= (w_op == OP_SW);
          end
        end
        S_MEM: begin
          if (i_mem_ready) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (!r_mem_we) r_mdr <= i_mem_rdata;
          end
        end
        S_WB: if (w_wr_en) r_regs[w_rd] <= (w_op == OP_LW) ? r_mdr : r_alu;
        default: ;
      endcase
      if (w_retire) begin
        r_pc      <= (r_state == S_EXEC && w_op == OP_BEQ && r_a == r_b) ?
                     r_pc + w_imm_pc : r_pc + PC_W'(1);
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  assign o_imem_addr = r_pc;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_alu[DADDR_W-1:0];
  assign o_mem_wdata = r_b;
  assign o_dbg_data  = w_rf[i_dbg_sel];
  assign o_zero      = r_zero;
  assign o_halted    = (r_state == S_HALT);
  assign o_illegal   = r_illegal;
  assign o_retired   = r_retired;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed self-checking bench for multicycle_datapath at default widths.
module tb_multicycle_datapath;

  logic        clk, rst_n;
  logic [4:0]  imem_addr;
  logic [15:0] imem_data;
  logic        mem_req, mem_we, mem_ready;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata, dbg_data, retired;
  logic [2:0]  dbg_sel;
  logic        zero, halted, illegal;
  logic [15:0] imem [32];

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b00010,
                         OP_OR = 5'b00011, OP_SLT = 5'b00100, OP_ADDI = 5'b01000,
                         OP_LW = 5'b01001, OP_SW = 5'b01010, OP_BEQ = 5'b01011,
                         OP_HALT = 5'b11111, OP_BAD = 5'b10101;

  multicycle_datapath dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_addr(imem_addr), .i_imem_data(imem_data),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .i_dbg_sel(dbg_sel), .o_dbg_data(dbg_data),
    .o_zero(zero), .o_halted(halted), .o_illegal(illegal), .o_retired(retired)
  );

  assign imem_data = imem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc_r(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 2'b00};
  endfunction

  function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [4:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = {OP_HALT, 11'd0};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_dbg(input logic [2:0] sel, output logic [15:0] v);
    dbg_sel = sel;
    #1;
    v = dbg_data;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    logic        any_nz;
    clear_imem();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (imem_addr !== 5'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", imem_addr); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", zero); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
    any_nz = 1'b0;
    for (int r = 0; r < 8; r++) begin
      rd_dbg(3'(r), v);
      if (v !== 16'd0) any_nz = 1'b1;
    end
    checks++; if (any_nz !== 1'b0) begin errors++; $display("FAIL reset_regs: got nonzero=%b want 0", any_nz); end
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    logic [15:0] v;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 3'd1, 3'd0, 5'd5);
    imem[1] = enc_i(OP_ADDI, 3'd2, 3'd0, 5'b11101);
    imem[2] = enc_r(OP_ADD, 3'd3, 3'd1, 3'd2);
    imem[3] = enc_r(OP_SUB, 3'd4, 3'd2, 3'd1);
    imem[4] = enc_r(OP_AND, 3'd5, 3'd1, 3'd2);
    imem[5] = enc_r(OP_OR,  3'd6, 3'd1, 3'd2);
    imem[6] = enc_r(OP_SLT, 3'd7, 3'd2, 3'd1);
    imem[7] = enc_r(OP_SUB, 3'd4, 3'd1, 3'd1);
    do_reset();
    cycles(12);
    rd_dbg(3'd3, v);
    checks++; if (v !== 16'd2) begin errors++; $display("FAIL alu_add_r3: got %h want 0002", v); end
    rd_dbg(3'd2, v);
    checks++; if (v !== 16'hFFFD) begin errors++; $display("FAIL alu_addi_neg_r2: got %h want fffd", v); end
    checks++; if (retired !== 16'd3) begin errors++; $display("FAIL alu_retired3: got %0d want 3", retired); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL alu_zero_after_add: got %b want 0", zero); end
    checks++; if (imem_addr !== 5'd3) begin errors++; $display("FAIL alu_pc3: got %0d want 3", imem_addr); end
    cycles(16);
    rd_dbg(3'd4, v);
    checks++; if (v !== 16'hFFF8) begin errors++; $display("FAIL alu_sub_r4: got %h want fff8", v); end
    rd_dbg(3'd5, v);
    checks++; if (v !== 16'h0005) begin errors++; $display("FAIL alu_and_r5: got %h want 0005", v); end
    rd_dbg(3'd6, v);
    checks++; if (v !== 16'hFFFD) begin errors++; $display("FAIL alu_or_r6: got %h want fffd", v); end
    rd_dbg(3'd7, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL alu_slt_r7: got %h want 0001", v); end
    checks++; if (retired !== 16'd7) begin errors++; $display("FAIL alu_retired7: got %0d want 7", retired); end
    cycles(4);
    rd_dbg(3'd4, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL alu_sub_zero_r4: got %h want 0000", v); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL alu_zero_set: got %b want 1", zero); end
  endtask

  task automatic test_mem();
    logic [15:0] v;
    int          hi;
    logic        stable;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 3'd1, 3'd0, 5'd5);
    imem[1] = enc_i(OP_SW,   3'd1, 3'd0, 5'd4);
    imem[2] = enc_i(OP_LW,   3'd4, 3'd0, 5'd4);
    do_reset();
    cycles(4);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sw_req_before_mem: got %b want 0", mem_req); end
    cycles(3);
    hi = 0;
    stable = 1'b1;
    for (int i = 0; i < 10 && mem_req === 1'b1; i++) begin
      hi++;
      if (mem_we !== 1'b1 || mem_addr !== 8'd4 || mem_wdata !== 16'd5) stable = 1'b0;
      mem_ready = (hi == 4);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    checks++; if (hi !== 4) begin errors++; $display("FAIL sw_req_cycles: got %0d want 4", hi); end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL sw_addr_wdata_stable: got %b want 1", stable); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sw_req_drop: got %b want 0", mem_req); end
    checks++; if (imem_addr !== 5'd2) begin errors++; $display("FAIL sw_pc: got %0d want 2", imem_addr); end
    checks++; if (retired !== 16'd2) begin errors++; $display("FAIL sw_retired: got %0d want 2", retired); end
    cycles(3);
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 8'd4}) begin errors++; $display("FAIL lw_req: got req=%b we=%b addr=%0d want 1 0 4", mem_req, mem_we, mem_addr); end
    mem_ready = 1'b1;
    mem_rdata = 16'd5;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 16'h0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lw_req_drop: got %b want 0", mem_req); end
    cycles(1);
    rd_dbg(3'd4, v);
    checks++; if (v !== 16'd5) begin errors++; $display("FAIL lw_r4: got %h want 0005", v); end
    checks++; if (retired !== 16'd3) begin errors++; $display("FAIL lw_retired: got %0d want 3", retired); end
  endtask

  task automatic test_branch();
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 3'd1, 3'd0, 5'd5);
    imem[1] = enc_i(OP_ADDI, 3'd2, 3'd0, 5'd1);
    imem[2] = enc_i(OP_ADDI, 3'd3, 3'd0, 5'd2);
    imem[3] = enc_i(OP_BEQ,  3'd1, 3'd1, 5'b11110);
    do_reset();
    cycles(12);
    checks++; if (imem_addr !== 5'd3) begin errors++; $display("FAIL beq_pc_before: got %0d want 3", imem_addr); end
    cycles(3);
    checks++; if (imem_addr !== 5'd1) begin errors++; $display("FAIL beq_taken_pc: got %0d want 1", imem_addr); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL beq_taken_zero: got %b want 1", zero); end
    checks++; if (retired !== 16'd4) begin errors++; $display("FAIL beq_taken_retired: got %0d want 4", retired); end
    imem[3] = enc_i(OP_BEQ, 3'd1, 3'd2, 5'd7);
    cycles(11);
    checks++; if (imem_addr !== 5'd4) begin errors++; $display("FAIL beq_not_taken_pc: got %0d want 4", imem_addr); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL beq_not_taken_zero: got %b want 0", zero); end
    checks++; if (retired !== 16'd7) begin errors++; $display("FAIL beq_not_taken_retired: got %0d want 7", retired); end
  endtask

  task automatic test_wrap_illegal_halt();
    logic [15:0] v;
    clear_imem();
    imem[0]  = enc_i(OP_ADDI, 3'd1, 3'd0, 5'd9);
    imem[1]  = enc_i(OP_BEQ,  3'd0, 3'd0, 5'b11110);
    imem[31] = enc_i(OP_BAD,  3'd1, 3'd1, 5'd1);
    do_reset();
    cycles(4);
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_before: got %b want 0", illegal); end
    cycles(3);
    checks++; if (imem_addr !== 5'd31) begin errors++; $display("FAIL branch_to_31: got %0d want 31", imem_addr); end
    imem[0] = enc_i(OP_ADDI, 3'd2, 3'd0, 5'd3);
    imem[1] = {OP_HALT, 11'd0};
    cycles(3);
    checks++; if (imem_addr !== 5'd0) begin errors++; $display("FAIL pc_wrap: got %0d want 0", imem_addr); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_set: got %b want 1", illegal); end
    rd_dbg(3'd1, v);
    checks++; if (v !== 16'd9) begin errors++; $display("FAIL illegal_no_write: got %h want 0009", v); end
    checks++; if (retired !== 16'd3) begin errors++; $display("FAIL illegal_retired: got %0d want 3", retired); end
    cycles(4);
    rd_dbg(3'd2, v);
    checks++; if (v !== 16'd3) begin errors++; $display("FAIL after_illegal_r2: got %h want 0003", v); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b want 1", illegal); end
    cycles(3);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_entered: got %b want 1", halted); end
    imem[1] = enc_i(OP_ADDI, 3'd2, 3'd0, 5'd1);
    cycles(20);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_held: got %b want 1", halted); end
    checks++; if (imem_addr !== 5'd1) begin errors++; $display("FAIL halt_pc_frozen: got %0d want 1", imem_addr); end
    checks++; if (retired !== 16'd4) begin errors++; $display("FAIL halt_retired: got %0d want 4", retired); end
    rd_dbg(3'd2, v);
    checks++; if (v !== 16'd3) begin errors++; $display("FAIL halt_regs_frozen: got %h want 0003", v); end
  endtask

  task automatic test_reset_mid_mem();
    logic [15:0] v;
    logic        any_nz;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 3'd1, 3'd0, 5'd5);
    imem[1] = enc_i(OP_SW,   3'd1, 3'd0, 5'd4);
    do_reset();
    cycles(7);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL midmem_req_up: got %b want 1", mem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midmem_req_async_drop: got %b want 0", mem_req); end
    checks++; if (imem_addr !== 5'd0) begin errors++; $display("FAIL midmem_pc: got %0d want 0", imem_addr); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL midmem_retired: got %0d want 0", retired); end
    any_nz = 1'b0;
    for (int r = 0; r < 8; r++) begin
      rd_dbg(3'(r), v);
      if (v !== 16'd0) any_nz = 1'b1;
    end
    checks++; if (any_nz !== 1'b0) begin errors++; $display("FAIL midmem_regs_cleared: got nonzero=%b want 0", any_nz); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_r0();
    logic [15:0] v;
    logic [15:0] exp_r0;
`ifdef MCDP_R0_ZERO_EN
    exp_r0 = 16'd0;
`else
    exp_r0 = 16'd7;
`endif
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 3'd0, 3'd0, 5'd7);
    do_reset();
    cycles(4);
    rd_dbg(3'd0, v);
    checks++; if (v !== exp_r0) begin errors++; $display("FAIL r0_write: got %h want %h", v, exp_r0); end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    dbg_sel = '0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_wrap_illegal_halt();
    test_reset_mid_mem();
    test_r0();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle successor to the single-cycle 16-bit datapath. It has an integrated control FSM, so no external control lines are needed, and a configurable data width and PC width. It adds a wait-state-capable data-memory handshake, a HALT state and a retired-instruction counter. Instruction memory stays combinational and external; data memory is external behind a req/ready handshake.

## Interface
- DATA_W, 16: register/ALU/data width, ≥ 8
- PC_W, 5: instruction address width, ≥ 5
- DADDR_W, 8: data-memory address width, ≤ DATA_W
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- imem_addr  out  PC_W  current PC
- imem_data  in  16  instruction at imem_addr, combinational
- mem_req  out  1  data access request
- mem_we  out  1  1 = store, 0 = load; valid while mem_req
- mem_addr  out  DADDR_W  ALU result [DADDR_W-1:0]
- mem_wdata  out  DATA_W  R[rd] for store
- mem_ready  in  1  access complete this cycle
- mem_rdata  in  DATA_W  load data, valid when mem_ready
- dbg_sel  in  3  register select for dbg_data
- dbg_data  out  DATA_W  R[dbg_sel], combinational
- zero  out  1  registered ALU zero from last EXEC
- halted  out  1  FSM in HALT
- illegal  out  1  sticky; undefined opcode seen
- retired  out  16  instructions completed, wraps at 16'hFFFF

## Operation
- Instruction fields: op [15:11], rd [10:8], rs [7:5], rt [4:2], imm5 [4:0]. imm5 is sign-extended to DATA_W (or to PC_W for branches).
- Opcodes:
  - 00000 ADD: rd = rs + rt
  - 00001 SUB: rd = rs − rt
  - 00010 AND
  - 00011 OR
  - 00100 SLT: signed compare, result 1/0
  - 01000 ADDI: rd = rs + imm
  - 01001 LW: rd = M[rs + imm]
  - 01010 SW: M[rs + imm] = rd
  - 01011 BEQ: if R[rd] == R[rs] then PC = PC + imm, else PC + 1
  - 11111 HALT
  - Any other opcode: executes as NOP and sets illegal.
- FSM states: FETCH → DECODE → EXEC → {MEM, WB, FETCH, HALT}.
  - FETCH: latch IR = imem_data.
  - DECODE: latch A = R[rs] and B = R[rt], or B = R[rd] for SW/BEQ.
  - EXEC: compute ALU result, latch ALUOut and zero.
  - R-type/ADDI/LW: EXEC → WB (LW goes through MEM first). SW: EXEC → MEM → FETCH.
  - BEQ/NOP: EXEC → FETCH, with PC updated on the EXEC edge. HALT: EXEC → HALT.
  - MEM holds until mem_ready; LW then → WB with MDR = mem_rdata.
  - WB writes rd and sets PC = PC + 1.
- PC update: non-branch PC is incremented once per instruction, on the final edge (WB, MEM exit for SW, EXEC for NOP/BEQ-not-taken).
- Arithmetic: modulo 2^DATA_W. PC is modulo 2^PC_W, so 31 + 1 → 0 at the default width.
- retired increments on the same edge as the PC update. HALT itself does not count.
- HALT is left only by reset. PC and registers are frozen, and the imem_data value is ignored.

## Timing
- Reset (asynchronous, immediate): PC = 0, all registers and IR/A/B/ALUOut/MDR = 0, state = FETCH, mem_req = 0, mem_we = 0, zero = 0, halted = 0, illegal = 0, retired = 0. Fetch starts on the first edge after RST_N rises.
- Latency in cycles:
  - ALU op and ADDI: 4
  - LW: 5 + waits
  - SW: 4 + waits
  - BEQ and NOP: 3
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are asserted on entry to MEM and held stable until the edge where mem_ready = 1 is sampled.
  - mem_req drops in the following cycle.
  - mem_ready = 1 in the first MEM cycle gives zero wait states.
  - mem_ready is ignored while mem_req = 0.
- Reset during MEM drops mem_req asynchronously; the access is abandoned with no register write.
- Write to rd and a read of the same register in the next instruction's DECODE: the new value is seen, because of multicycle spacing.
- dbg_data reflects a write from the edge after WB.

## Configuration
- MCDP_R0_ZERO_EN:
  - Defined: R0 reads as 0 on every path (A, B, mem_wdata, dbg_data), and writes to R0 are discarded.
  - Undefined: R0 is an ordinary writable register.

## Test plan
- Reset then ADDI R1,R0,5; ADDI R2,R0,−3; ADD R3,R1,R2 → R3 = 2, retired = 3 after 12 cycles, zero = 0.
- SW R1,[R0+4] with mem_ready delayed 3 cycles → mem_req held high 4 cycles with mem_addr = 4 and mem_wdata = 5. Then LW R4,[R0+4] with rdata = 5 → R4 = 5.
- BEQ R1,R1,−2 at PC 3 → PC = 1 after 3 cycles. BEQ on unequal registers → PC = 4. PC 31 with NOP → PC = 0.
- Opcode 10101 → illegal = 1 (sticky), no register change, PC + 1. HALT → halted = 1 and PC frozen for 20 cycles.
- RST_N pulsed low mid-MEM → mem_req = 0 immediately, PC = 0, all registers = 0.
- ADDI R0,R0,7 → dbg_data(sel = 0) = 0 with MCDP_R0_ZERO_EN defined, 7 without.
